acc_request_scheduler: RTL

- Sequences the 2-bit accumulate datapath (4-to-2 encoder, 2-bit adder, D flip-flop pair, 7-segment display).
- Replaces the direct switch-to-encoder path with a scheduled one: four asynchronous request lines are synchronised and edge-detected, pending requests are queued, and a round-robin arbiter issues exactly one add command per grant slot.
- After each grant the block waits a programmable number of cycles, so the displayed accumulator value stays stable before the next update.

---
 rtl/acc_request_scheduler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/acc_request_scheduler.sv
// Round-robin scheduler for the 2-bit accumulate datapath: synchronises four request
// lines, queues their rising edges and issues one add command per grant slot.
module acc_request_scheduler #(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       inrst,
  input  logic [3:0] req,
  output logic       add_en,
  output logic [1:0] add_val,
  output logic [3:0] grant,
  output logic       busy,
  output logic [3:0] pending
);

  localparam int unsigned REQ_W = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REQ_W-1:0]   sync_q [SYNC_STAGES];
  logic [REQ_W-1:0]   prev_q;
  logic [REQ_W-1:0]   pending_q, pending_d;
  logic [REQ_W-1:0]   synced, rise, clr;
  logic               found;
  logic [IDX_W-1:0]   sel, cand;

  // Request synchroniser chain plus one history stage for edge detection
  always_ff @(posedge clk or negedge inrst) begin
    if (!inrst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= req;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= synced;
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~prev_q;

  // A new rise beats the clear of the same bit, so a request landing on its own grant is kept
  assign clr       = (state_q == GRANT) ? (REQ_W'(1) << idx_q) : '0;
  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge clk or negedge inrst) begin
    if (!inrst) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending = pending_q;

  // First pending bit at or after the round-robin pointer
  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    cand  = ptr_q;
    for (int k = 0; k < REQ_W; k++) begin
      cand = ptr_q + IDX_W'(k);
      if (!found && pending_q[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge inrst) begin
    if (!inrst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          idx_d   = sel;
          state_d = GRANT;
        end
      end
      GRANT: begin
        ptr_d = idx_q + IDX_W'(1);
        if (HOLD_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs registered from next-state values so they align with the state register
  always_ff @(posedge clk or negedge inrst) begin
    if (!inrst) begin
      add_en  <= 1'b0;
      add_val <= '0;
      grant   <= '0;
      busy    <= 1'b0;
    end else begin
      add_en  <= (state_d == GRANT);
      add_val <= idx_d;
      grant   <= (state_d == GRANT) ? (REQ_W'(1) << idx_d) : '0;
      busy    <= (state_d != IDLE);
    end
  end

endmodule
